// File: rtl/bist_pkg.sv
// Shared definitions for the BIST pattern controller: widths, default seed,
// controller state encoding and feedback tap positions.
package bist_pkg;

    localparam int BIST_WIDTH = 5;
    localparam int BIST_CNT_W = 8;
    localparam logic [BIST_WIDTH-1:0] BIST_DEFAULT_SEED = 5'b01111;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        CMP  = 3'd3,
        DONE = 3'd4
    } state_e;

    // Both shift registers feed back bit4 ^ bit2 (polynomial x^5 + x^3 + 1)
    localparam int LFSR_TAP_HI = 4;
    localparam int LFSR_TAP_LO = 2;
    localparam int MISR_TAP_HI = 4;
    localparam int MISR_TAP_LO = 2;

endpackage

// File: rtl/bist_bs_lfsr.sv
// Seedable, enable-gated LFSR whose output pattern swaps its two low bits
// whenever the top bit is set.
module bist_bs_lfsr
    import bist_pkg::*;
#(
    parameter int WIDTH = BIST_WIDTH,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = BIST_DEFAULT_SEED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] seed_i,
    output logic [WIDTH-1:0] pattern_o
);

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;

    // A zero seed would lock the register at zero, so the default seed stands in
    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = (seed_i == '0) ? DEFAULT_SEED : seed_i;
        end else if (en_i) begin
            lfsr_d = {lfsr_q[WIDTH-2:0], lfsr_q[LFSR_TAP_HI] ^ lfsr_q[LFSR_TAP_LO]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= DEFAULT_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    always_comb begin
        pattern_o = lfsr_q;
        if (lfsr_q[WIDTH-1]) begin
            pattern_o = {lfsr_q[WIDTH-1:2], lfsr_q[0], lfsr_q[1]};
        end
    end

endmodule

// File: rtl/bist_pattern_controller.sv
// BIST sequencer: applies a programmed number of LFSR patterns to the CUT,
// compacts the responses in a MISR and compares against a golden signature.
module bist_pattern_controller
    import bist_pkg::*;
#(
    parameter int WIDTH = BIST_WIDTH,
    parameter int CNT_W = BIST_CNT_W,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = BIST_DEFAULT_SEED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] seed,
    input  logic [CNT_W-1:0] pattern_count,
    input  logic [WIDTH-1:0] golden_sig,
    input  logic [WIDTH-1:0] cut_resp,
    output logic [WIDTH-1:0] pattern,
    output logic             pattern_valid,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature
);

    state_e           state_q;
    logic [WIDTH-1:0] misr_q;
    logic [CNT_W-1:0] counter_q;
    logic             patternValid_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;

    logic             abortHit;
    logic             lfsrLoad;
    logic             lfsrEn;
    logic [WIDTH-1:0] misrStep;

    // Abort only matters while a run is in flight; IDLE and DONE ignore it
    assign abortHit = abort && (state_q inside {LOAD, RUN, CMP});
    assign lfsrLoad = (state_q == LOAD) && !abort;
    assign lfsrEn   = (state_q == RUN) && !abort;

    assign misrStep = {misr_q[WIDTH-2:0], misr_q[MISR_TAP_HI] ^ misr_q[MISR_TAP_LO]} ^ cut_resp;

    bist_bs_lfsr #(
        .WIDTH        (WIDTH),
        .DEFAULT_SEED (DEFAULT_SEED)
    ) u_lfsr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (lfsrLoad),
        .en_i      (lfsrEn),
        .seed_i    (seed),
        .pattern_o (pattern)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            misr_q         <= '0;
            counter_q      <= '0;
            patternValid_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
        end else if (abortHit) begin
            state_q        <= IDLE;
            patternValid_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    misr_q    <= '0;
                    counter_q <= pattern_count;
                    if (pattern_count != '0) begin
                        state_q        <= RUN;
                        patternValid_q <= 1'b1;
                    end else begin
                        state_q <= CMP;
                    end
                end
                RUN: begin
                    misr_q    <= misrStep;
                    counter_q <= counter_q - CNT_W'(1);
                    if (counter_q == CNT_W'(1)) begin
                        state_q        <= CMP;
                        patternValid_q <= 1'b0;
                    end
                end
                CMP: begin
                    pass_q  <= (misr_q == golden_sig);
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= DONE;
                end
                DONE: begin
                    if (start) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q        <= IDLE;
                    patternValid_q <= 1'b0;
                    busy_q         <= 1'b0;
                    done_q         <= 1'b0;
                    pass_q         <= 1'b0;
                end
            endcase
        end
    end

    assign pattern_valid = patternValid_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign signature     = misr_q;

endmodule
